// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx shared types and defaults.
// Reused by the matching shift-in receiver.
package serial_word_tx_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Parallel word handshake into serial_word_tx.
// master = producer, slave = transmitter.
interface serial_word_tx_if
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-time counter: counts 0..DIV-1, wraps.
// last is high in the final cycle of a bit.
module bit_timer
  import serial_word_tx_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic last
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign last = (r_cnt == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Framed serial transmitter: start, data LSB first, stop.
// tx is registered, so it trails the FSM state by one cycle.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_word_tx_if.slave  s_in,
  output logic             tx,
  output logic             busy
);

  localparam int IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic             r_tx;
  logic             w_tx;
  logic             w_accept;
  logic             w_last;
  logic             w_clear;

  assign s_in.in_ready = (r_state == IDLE);
  assign w_accept      = s_in.in_ready & s_in.in_valid;
  assign w_clear       = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign tx            = r_tx;

  bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .last  (w_last)
  );

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_last) w_next = DATA;
      end
      DATA: begin
        w_tx = r_shreg[0];
        if (w_last && (r_idx == LAST_IDX))
          w_next = STOP;
      end
      STOP: begin
        if (w_last) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Async reset drops tx high at once: an aborted frame gets no stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_shreg <= s_in.in_data;
      r_idx   <= '0;
    end else if ((r_state == DATA) && w_last) begin
      r_shreg <= r_shreg >> 1;
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end
  end

endmodule
